hazard_stall_unit: RTL

- Companion to the EX-stage forwarding logic in the 5-stage RISC-V pipeline.
- Forwarding resolves hazards by bypassing data. This block resolves the hazards forwarding cannot:
  - load-use stall, detected in ID;
  - control-flush on a branch/jump taken in EX;
  - whole-pipeline freeze while a data-memory access in MEM waits for ready.
- It drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- A small FSM with a timeout counter supervises the memory wait.

---
 rtl/hazard_stall_unit_pkg.sv | 21 ++
 rtl/hazard_perf_counter.sv | 21 ++
 rtl/hazard_stall_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the memory-wait FSM encoding and register-index helpers.
package hazard_stall_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hsu_state_t;

    // True when an ID operand is really read and names the EX destination.
    function automatic logic reg_match(input logic                 use_rs,
                                       input logic [REG_IDX_W-1:0] rs,
                                       input logic [REG_IDX_W-1:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter for hazard statistics.
// Latency: count reflects an event one cycle after inc; no backpressure, holds at all-ones.
// Reset: asynchronous active-low.
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and memory-wait freeze control; counters under HAZARD_PERF_EN.
// Latency: enables/flushes are combinational; FSM and wait counter update on the next edge.
// Backpressure: MemReady low freezes the whole pipeline; ERROR freezes until reset.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] Rs1_ID,
    input  logic [REG_IDX_W-1:0] Rs2_ID,
    input  logic                 Use_Rs1_ID,
    input  logic                 Use_Rs2_ID,
    input  logic [REG_IDX_W-1:0] RD_EX,
    input  logic                 MemRead_EX,
    input  logic                 Taken_EX,
    input  logic                 MemReq_MEM,
    input  logic                 MemReady,
    output logic                 PC_Write,
    output logic                 IFID_Write,
    output logic                 IFID_Flush,
    output logic                 IDEX_Write,
    output logic                 IDEX_Flush,
    output logic                 EXMEM_Write,
    output logic                 MEMWB_Flush,
    output logic                 Mem_Timeout,
    output logic [CNT_W-1:0]     Stall_Cnt,
    output logic [CNT_W-1:0]     Flush_Cnt,
    output logic [CNT_W-1:0]     Freeze_Cnt
);

    hsu_state_t      state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            freeze;
    logic            load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A ready in MEM_WAIT releases the freeze in the same cycle it arrives.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MemReq_MEM && !MemReady) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (MemReady) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign load_use = MemRead_EX && (RD_EX != REG_X0) &&
                      (reg_match(Use_Rs1_ID, Rs1_ID, RD_EX) ||
                       reg_match(Use_Rs2_ID, Rs2_ID, RD_EX));

    // Taken branch outranks load-use: the ID instruction is on the wrong path.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Flush  = 1'b0;
        EXMEM_Write = 1'b1;
        MEMWB_Flush = 1'b0;
        if (freeze) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Flush = 1'b1;
        end else if (Taken_EX) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (load_use) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    assign Mem_Timeout = (state_q == ST_ERROR);

`ifdef HAZARD_PERF_EN
    logic stall_applied;
    logic flush_applied;

    assign stall_applied = !freeze && !Taken_EX && load_use;
    assign flush_applied = !freeze && Taken_EX;

    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_applied),
        .count (Stall_Cnt)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_applied),
        .count (Flush_Cnt)
    );

    hazard_perf_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze),
        .count (Freeze_Cnt)
    );
`else
    assign Stall_Cnt  = '0;
    assign Flush_Cnt  = '0;
    assign Freeze_Cnt = '0;
`endif

endmodule
